// File: rtl/alu_regfile_core.sv
// alu_regfile_core: register-file ALU with valid/ready issue, persistent flags, multi-cycle shifts.
// Define ALU_MUL_EN to build the shift-add multiplier for opcode 0x14; otherwise 0x14 is illegal.
module alu_regfile_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH-1:0] src_a,
    input  logic [ADDR_WIDTH-1:0] src_b,
    input  logic                  use_imm,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_n,
    output logic                  flag_v,
    output logic                  illegal,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int W    = DATA_WIDTH;
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int SW   = $clog2(DATA_WIDTH);
    localparam int CW   = SW + 1;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_ADC = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_SBB = 8'h03;
    localparam logic [7:0] OP_NEG = 8'h04;
    localparam logic [7:0] OP_AND = 8'h08;
    localparam logic [7:0] OP_OR  = 8'h09;
    localparam logic [7:0] OP_XOR = 8'h0A;
    localparam logic [7:0] OP_NOT = 8'h0B;
    localparam logic [7:0] OP_ROR = 8'h0E;
    localparam logic [7:0] OP_ROL = 8'h0F;
    localparam logic [7:0] OP_MOV = 8'h10;
    localparam logic [7:0] OP_CMP = 8'h11;
    localparam logic [7:0] OP_SHL = 8'h12;
    localparam logic [7:0] OP_SHR = 8'h13;
`ifdef ALU_MUL_EN
    localparam logic [7:0] OP_MUL = 8'h14;
`endif

    typedef enum logic {IDLE, EXEC} state_e;
    typedef enum logic [1:0] {M_SHL, M_SHR, M_MUL} mop_e;

    state_e                state_q;
    mop_e                  mop_q, mop_d;
    logic [W-1:0]          regs_q [NREG];
    logic [W-1:0]          y_q, sh_q, sh_step, res_m;
    logic                  z_q, c_q, n_q, v_q, ov_q, ill_q;
    logic                  sc_q, sc_step, nz_q, c_m, v_m;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] dst_q;
`ifdef ALU_MUL_EN
    logic [W-1:0]          hi_q, mc_q, hi_step;
    logic [W:0]            psum;
`endif
    logic [W-1:0]          a, b, r;
    logic [W:0]            ext;
    logic [SW-1:0]         n_amt;
    logic                  c, v, legal, wb, multi, accept;

    assign in_ready  = reset && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = ov_q;
    assign illegal   = ill_q;
    assign Y         = y_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;
    assign dbg_data  = regs_q[dbg_addr];

    always_comb begin
        a     = regs_q[src_a];
        b     = use_imm ? imm : regs_q[src_b];
        n_amt = b[SW-1:0];
        ext   = '0;
        r     = '0;
        c     = 1'b0;
        v     = 1'b0;
        legal = 1'b1;
        wb    = 1'b1;
        multi = 1'b0;
        mop_d = M_SHL;
        cnt_d = (n_amt == '0) ? CW'(1) : {1'b0, n_amt};
        unique case (opcode)
            OP_ADD, OP_ADC: begin
                ext = {1'b0, a} + {1'b0, b}
                    + {{W{1'b0}}, (opcode == OP_ADC) & c_q};
                r   = ext[W-1:0];
                c   = ext[W];
                v   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                // bit W of the widened difference is the borrow
                ext = {1'b0, a} - {1'b0, b}
                    - {{W{1'b0}}, (opcode == OP_SBB) & c_q};
                r   = ext[W-1:0];
                c   = ext[W];
                v   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
                wb  = (opcode != OP_CMP);
            end
            OP_NEG: begin
                ext = {(W+1){1'b0}} - {1'b0, a};
                r   = ext[W-1:0];
                c   = ext[W];
                v   = a[W-1] & r[W-1];
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_MOV: r = b;
            OP_ROR: begin
                r = {a[0], a[W-1:1]};
                c = a[0];
            end
            OP_ROL: begin
                r = {a[W-2:0], a[W-1]};
                c = a[W-1];
            end
            OP_SHL: begin
                multi = 1'b1;
                mop_d = M_SHL;
            end
            OP_SHR: begin
                multi = 1'b1;
                mop_d = M_SHR;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                multi = 1'b1;
                mop_d = M_MUL;
                cnt_d = CW'(W);
            end
`endif
            default: begin
                legal = 1'b0;
                wb    = 1'b0;
            end
        endcase
    end

    always_comb begin
        sh_step = sh_q;
        sc_step = sc_q;
`ifdef ALU_MUL_EN
        hi_step = hi_q;
        psum    = '0;
`endif
        unique case (mop_q)
            M_SHL: if (!nz_q) begin
                sc_step = sh_q[W-1];
                sh_step = {sh_q[W-2:0], 1'b0};
            end
            M_SHR: if (!nz_q) begin
                sc_step = sh_q[0];
                sh_step = {1'b0, sh_q[W-1:1]};
            end
            default: begin
`ifdef ALU_MUL_EN
                // {hi,lo} product shifts right; lo starts as the multiplier
                psum    = {1'b0, hi_q} + (sh_q[0] ? {1'b0, mc_q} : '0);
                hi_step = psum[W:1];
                sh_step = {psum[0], sh_q[W-1:1]};
`endif
            end
        endcase
    end

    always_comb begin
        res_m = sh_step;
        c_m   = sc_step;
        v_m   = 1'b0;
`ifdef ALU_MUL_EN
        if (mop_q == M_MUL) begin
            c_m = |hi_step;
            v_m = |hi_step;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            y_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            ov_q    <= 1'b0;
            ill_q   <= 1'b0;
            sh_q    <= '0;
            sc_q    <= 1'b0;
            nz_q    <= 1'b0;
            cnt_q   <= '0;
            mop_q   <= M_SHL;
            dst_q   <= '0;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
            mc_q    <= '0;
`endif
        end else begin
            ov_q  <= 1'b0;
            ill_q <= 1'b0;
            unique case (state_q)
                IDLE: if (accept) begin
                    if (!legal) begin
                        ov_q  <= 1'b1;
                        ill_q <= 1'b1;
                    end else if (multi) begin
                        state_q <= EXEC;
                        mop_q   <= mop_d;
                        cnt_q   <= cnt_d;
                        dst_q   <= dst;
                        sc_q    <= 1'b0;
                        nz_q    <= (n_amt == '0);
                        sh_q    <= a;
`ifdef ALU_MUL_EN
                        hi_q    <= '0;
                        mc_q    <= a;
                        if (mop_d == M_MUL) sh_q <= b;
`endif
                    end else begin
                        if (wb) begin
                            regs_q[dst] <= r;
                            y_q         <= r;
                        end
                        z_q  <= (r == '0);
                        n_q  <= r[W-1];
                        c_q  <= c;
                        v_q  <= v;
                        ov_q <= 1'b1;
                    end
                end
                EXEC: begin
                    sh_q  <= sh_step;
                    sc_q  <= sc_step;
                    cnt_q <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
                    hi_q  <= hi_step;
`endif
                    if (cnt_q == CW'(1)) begin
                        state_q       <= IDLE;
                        regs_q[dst_q] <= res_m;
                        y_q           <= res_m;
                        z_q           <= (res_m == '0);
                        n_q           <= res_m[W-1];
                        c_q           <= c_m;
                        v_q           <= v_m;
                        ov_q          <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
